disassembler: RTL and testbench

//  Inverse of the text-to-machine-code assembler. Accepts one 32-bit RV32I instruction word through a valid/ready handshake.

---
 rtl/disassembler.sv | 216 +++++++++++++++++++++
 tb/tb_disassembler.sv | 123 ++++++++++++
 2 files changed

// File: rtl/disassembler.sv
// disassembler: turns one RV32I instruction word into its assembly text, streamed as one ASCII character per handshake.
module disassembler #(
    parameter int         IMM_HEX_DIGITS = 8,
    parameter int         U_HEX_DIGITS   = 5,
    parameter logic [7:0] EOL_CHAR       = 8'h0A
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        inst_valid,
    input  logic [31:0] inst_in,
    output logic        inst_ready,
    output logic [7:0]  char_out,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        char_last,
    output logic        error_flag
);
    typedef enum logic [2:0] {S_IDLE, S_MNEM, S_SPACE, S_OPND, S_COMMA, S_SEP, S_EOL, S_DONE} state_t;
    typedef enum logic [2:0] {F_NONE, F_R, F_I, F_SH, F_S, F_B, F_U, F_J} fmt_t;
    state_t      r_state;
    logic [31:0] r_inst, r_sh;
    logic [3:0]  r_idx;
    logic [1:0]  r_slot;
    logic [7:0]  r_char;
    logic        r_valid, r_last, r_err;
    logic [6:0]  w_op, w_f7;
    logic [2:0]  w_f3, w_mpos;
    logic [4:0]  w_rd, w_rs1, w_rs2, w_reg, w_tensv, w_ones;
    logic [55:0] w_mn;
    fmt_t        w_fmt;
    logic        w_ill, w_isimm, w_end;
    logic [1:0]  w_nops, w_tens;
    logic [3:0]  w_mlen, w_ndig, w_nib;
    logic [31:0] w_imm;
    logic [7:0]  w_hex, w_char;
    assign w_op  = r_inst[6:0];
    assign w_rd  = r_inst[11:7];
    assign w_f3  = r_inst[14:12];
    assign w_rs1 = r_inst[19:15];
    assign w_rs2 = r_inst[24:20];
    assign w_f7  = r_inst[31:25];
    // Mnemonics are right-aligned in a 7-char field; anything left as "illegal" carries no operands.
    always_comb begin
        w_mn  = "illegal";
        w_fmt = F_NONE;
        case (w_op)
            7'b0110111: begin w_mn = "lui"; w_fmt = F_U; end
            7'b0010111: begin w_mn = "auipc"; w_fmt = F_U; end
            7'b1101111: begin w_mn = "jal"; w_fmt = F_J; end
            7'b1100111: begin w_fmt = F_I; if (w_f3 == 3'd0) w_mn = "jalr"; end
            7'b1100011: begin
                w_fmt = F_B;
                case (w_f3)
                    3'd0: w_mn = "beq";
                    3'd1: w_mn = "bne";
                    3'd4: w_mn = "blt";
                    3'd5: w_mn = "bge";
                    3'd6: w_mn = "bltu";
                    3'd7: w_mn = "bgeu";
                    default: ;
                endcase
            end
            7'b0000011: begin
                w_fmt = F_I;
                case (w_f3)
                    3'd0: w_mn = "lb";
                    3'd1: w_mn = "lh";
                    3'd2: w_mn = "lw";
                    3'd4: w_mn = "lbu";
                    3'd5: w_mn = "lhu";
                    default: ;
                endcase
            end
            7'b0100011: begin
                w_fmt = F_S;
                case (w_f3)
                    3'd0: w_mn = "sb";
                    3'd1: w_mn = "sh";
                    3'd2: w_mn = "sw";
                    default: ;
                endcase
            end
            7'b0010011: begin
                w_fmt = (w_f3 == 3'd1 || w_f3 == 3'd5) ? F_SH : F_I;
                case (w_f3)
                    3'd0: w_mn = "addi";
                    3'd1: if (w_f7 == 7'h00) w_mn = "slli";
                    3'd2: w_mn = "slti";
                    3'd3: w_mn = "sltiu";
                    3'd4: w_mn = "xori";
                    3'd5: if (w_f7 == 7'h00) w_mn = "srli"; else if (w_f7 == 7'h20) w_mn = "srai";
                    3'd6: w_mn = "ori";
                    default: w_mn = "andi";
                endcase
            end
            7'b0110011: begin
                w_fmt = F_R;
                if (w_f7 == 7'h00) begin
                    case (w_f3)
                        3'd0: w_mn = "add";
                        3'd1: w_mn = "sll";
                        3'd2: w_mn = "slt";
                        3'd3: w_mn = "sltu";
                        3'd4: w_mn = "xor";
                        3'd5: w_mn = "srl";
                        3'd6: w_mn = "or";
                        default: w_mn = "and";
                    endcase
                end else if (w_f7 == 7'h20 && w_f3 == 3'd0) w_mn = "sub";
                else if (w_f7 == 7'h20 && w_f3 == 3'd5) w_mn = "sra";
            end
            default: ;
        endcase
    end
    assign w_ill  = w_mn == "illegal";
    assign w_mlen = w_mn[55:48] != 8'h00 ? 4'd7 : w_mn[47:40] != 8'h00 ? 4'd6 : w_mn[39:32] != 8'h00 ? 4'd5 :
                    w_mn[31:24] != 8'h00 ? 4'd4 : w_mn[23:16] != 8'h00 ? 4'd3 : 4'd2;
    assign w_mpos = 3'(w_mlen - 4'd1 - r_idx);
    assign w_nops = w_ill ? 2'd0 : (w_fmt == F_U || w_fmt == F_J) ? 2'd2 : 2'd3;
    assign w_isimm = (r_slot == 2'd2 && w_fmt != F_R) || (r_slot == 2'd1 && (w_fmt == F_U || w_fmt == F_J));
    assign w_reg = r_slot == 2'd0 ? (w_fmt == F_S ? w_rs2 : w_fmt == F_B ? w_rs1 : w_rd) :
                   r_slot == 2'd1 ? (w_fmt == F_B ? w_rs2 : w_rs1) : w_rs2;
    // Immediates are left-aligned so the shift register always emits its top nibble first.
    assign w_imm = w_fmt == F_U  ? {r_inst[31:12], 12'h000} :
                   w_fmt == F_SH ? {27'h0, r_inst[24:20]} :
                   w_fmt == F_S  ? {{20{r_inst[31]}}, r_inst[31:25], r_inst[11:7]} :
                   w_fmt == F_B  ? {{19{r_inst[31]}}, r_inst[31], r_inst[7], r_inst[30:25], r_inst[11:8], 1'b0} :
                   w_fmt == F_J  ? {{11{r_inst[31]}}, r_inst[31], r_inst[19:12], r_inst[20], r_inst[30:21], 1'b0} :
                   {{20{r_inst[31]}}, r_inst[31:20]};
    assign w_ndig  = w_fmt == F_U ? 4'(U_HEX_DIGITS) : 4'(IMM_HEX_DIGITS);
    assign w_nib   = r_sh[31:28];
    assign w_hex   = {4'h0, w_nib} + (w_nib < 4'd10 ? 8'h30 : 8'h37);
    assign w_tens  = w_reg >= 5'd30 ? 2'd3 : w_reg >= 5'd20 ? 2'd2 : w_reg >= 5'd10 ? 2'd1 : 2'd0;
    assign w_tensv = w_tens == 2'd3 ? 5'd30 : w_tens == 2'd2 ? 5'd20 : w_tens == 2'd1 ? 5'd10 : 5'd0;
    assign w_ones  = w_reg - w_tensv;
    always_comb begin
        w_char = EOL_CHAR;
        w_end  = 1'b1;
        case (r_state)
            S_MNEM: begin
                w_char = w_mn[{w_mpos, 3'b000} +: 8];
                w_end  = r_idx == w_mlen - 4'd1;
            end
            S_SPACE, S_SEP: w_char = " ";
            S_COMMA: w_char = ",";
            S_OPND: begin
                if (w_isimm) begin
                    w_char = r_idx == 4'd0 ? "0" : r_idx == 4'd1 ? "x" : w_hex;
                    w_end  = r_idx == w_ndig + 4'd1;
                end else begin
                    w_char = r_idx == 4'd0 ? "x" : (r_idx == 4'd1 && w_tens != 2'd0) ? 8'h30 + {6'h0, w_tens} : 8'h30 + {3'h0, w_ones};
                    w_end  = r_idx == 4'd2 || (r_idx == 4'd1 && w_tens == 2'd0);
                end
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
            r_inst  <= '0;
            r_sh    <= '0;
            r_idx   <= '0;
            r_slot  <= '0;
            r_char  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (r_state == S_IDLE) begin
                if (inst_valid) begin
                    r_inst  <= inst_in;
                    r_state <= S_MNEM;
                    r_idx   <= '0;
                    r_slot  <= '0;
                end
            end else if (!r_valid || char_ready) begin
                if (r_state == S_DONE) begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end else begin
                    r_char  <= w_char;
                    r_valid <= 1'b1;
                    r_last  <= r_state == S_EOL;
                    r_err   <= r_state == S_MNEM && !r_valid && w_ill;
                    r_idx   <= w_end ? 4'd0 : r_idx + 4'd1;
                    case (r_state)
                        S_MNEM: begin
                            r_sh <= w_imm;
                            if (w_end) r_state <= w_nops == 2'd0 ? S_EOL : S_SPACE;
                        end
                        S_SPACE: r_state <= S_OPND;
                        S_OPND: begin
                            if (w_isimm && r_idx >= 4'd2) r_sh <= r_sh << 4;
                            if (w_end) r_state <= r_slot == w_nops - 2'd1 ? S_EOL : S_COMMA;
                        end
                        S_COMMA: r_state <= S_SEP;
                        S_SEP: begin
                            r_state <= S_OPND;
                            r_slot  <= r_slot + 2'd1;
                        end
                        S_EOL: r_state <= S_DONE;
                        default: ;
                    endcase
                end
            end
        end
    end
    assign inst_ready = r_state == S_IDLE;
    assign char_out   = r_char;
    assign char_valid = r_valid;
    assign char_last  = r_last;
    assign error_flag = r_err;
endmodule

// File: tb/tb_disassembler.sv
// tb_disassembler: directed words with hand-written expected text, checked by a scoreboard monitor on the character stream.
module tb_disassembler;
    logic        clk_in = 1'b0, rst_in = 1'b0, inst_valid = 1'b0, char_ready = 1'b1;
    logic [31:0] inst_in = '0;
    logic        inst_ready, char_valid, char_last, error_flag;
    logic [7:0]  char_out;
    logic [8:0]  q[$];
    logic [8:0]  held, e;
    int          checks = 0, errors = 0, beats = 0, accepts = 0, pulses = 0;
    bit          rnd = 1'b0, stalled = 1'b0;

    disassembler dut (
        .clk_in(clk_in), .rst_in(rst_in), .inst_valid(inst_valid), .inst_in(inst_in),
        .inst_ready(inst_ready), .char_out(char_out), .char_valid(char_valid),
        .char_ready(char_ready), .char_last(char_last), .error_flag(error_flag)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: everything sampled on the falling edge reflects what the next rising edge will see.
    always @(negedge clk_in) begin
        if (rst_in) stalled = 1'b0;
        else begin
            if (stalled) chk("stall_hold", {char_valid, char_last, char_out}, {1'b1, held});
            stalled = char_valid && !char_ready;
            held = {char_last, char_out};
            if (error_flag) pulses++;
            if (inst_valid && inst_ready) accepts++;
            if (char_valid && char_ready) begin
                beats++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_char: got %h expected none", char_out);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("char%0d", beats), {char_last, char_out}, e);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk_in);
        #1 char_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic push_line(input string s);
        for (int i = 0; i < s.len(); i++) q.push_back({1'b0, s[i]});
        q.push_back({1'b1, 8'h0A});
    endtask

    task automatic send(input logic [31:0] w, input string s, input bit hold);
        int n, a0, p0;
        a0 = accepts;
        p0 = pulses;
        push_line(s);
        inst_in = w;
        inst_valid = 1'b1;
        n = 0;
        while (!inst_ready && n < 50) begin @(posedge clk_in); #1; n++; end
        @(posedge clk_in); #1;
        if (!hold) inst_valid = 1'b0;
        chk("latency_edge1", char_valid, 0);
        @(posedge clk_in); #1;
        chk("latency_edge2", char_valid, 1);
        n = 0;
        while ((q.size() != 0 || !inst_ready) && n < 400) begin
            if (hold && char_valid && char_last) inst_valid = 1'b0;
            @(posedge clk_in); #1;
            n++;
        end
        inst_valid = 1'b0;
        chk("line_done", n < 400, 1);
        chk("accepts", accepts - a0, 1);
        chk("err_pulses", pulses - p0, s == "illegal");
    endtask

    initial begin
        int n, b0;
        #1 rst_in = 1'b1;
        #1 chk("reset_state", {inst_ready, char_valid, char_last, error_flag, char_out}, {4'b1000, 8'h00});
        @(posedge clk_in); @(posedge clk_in); #1 rst_in = 1'b0;
        send(32'h003100B3, "add x1, x2, x3", 1'b0);
        send(32'hFFC00293, "addi x5, x0, 0xFFFFFFFC", 1'b0);
        send(32'h12345FB7, "lui x31, 0x12345", 1'b0);
        send(32'hFE0008E3, "beq x0, x0, 0xFFFFFFF0", 1'b0);
        send(32'h40315233, "sra x4, x2, x3", 1'b0);
        send(32'h00512423, "sw x5, x2, 0x00000008", 1'b0);
        send(32'h4075D513, "srai x10, x11, 0x00000007", 1'b0);
        send(32'hFFDFF0EF, "jal x1, 0xFFFFFFFC", 1'b0);
        send(32'h00003003, "illegal", 1'b0);
        rnd = 1'b1;
        send(32'h003100B3, "add x1, x2, x3", 1'b0);
        rnd = 1'b0;
        send(32'hFFFFFFFF, "illegal", 1'b1);
        // Reset while beat 6 of a line is on the output.
        push_line("add x1, x2, x3");
        b0 = beats;
        inst_in = 32'h003100B3;
        inst_valid = 1'b1;
        @(posedge clk_in); #1 inst_valid = 1'b0;
        n = 0;
        while (beats - b0 < 5 && n < 100) begin @(posedge clk_in); #1; n++; end
        chk("reach_beat6", beats - b0, 5);
        rst_in = 1'b1;
        q.delete();
        #1 chk("midline_reset", {inst_ready, char_valid, char_last, error_flag, char_out}, {4'b1000, 8'h00});
        @(posedge clk_in); #1 rst_in = 1'b0;
        send(32'h003100B3, "add x1, x2, x3", 1'b0);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
